// File: rtl/muldiv_seq_if.sv
// Handshake and data bundle between the execute-stage control and muldiv_seq.
// The control side drives the request (master); the sequencer answers (slave).
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             iStart;
    logic             iKill;
    logic [4:0]       iControl;
    logic [WIDTH-1:0] iA;
    logic [WIDTH-1:0] iB;
    logic             oReady;
    logic             oDone;
    logic [WIDTH-1:0] oResult;
    logic             oZero;
    logic             oIllegal;

    modport master (
        output iStart, iKill, iControl, iA, iB,
        input  oReady, oDone, oResult, oZero, oIllegal
    );

    modport slave (
        input  iStart, iKill, iControl, iA, iB,
        output oReady, oDone, oResult, oZero, oIllegal
    );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle RV32M sequencer (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Iterative radix-2 shift-add multiply and restoring divide on operand magnitudes,
// with a final two's-complement fix-up. Division by zero, signed overflow and
// non-M opcodes complete early. Defining MULDIV_FAST_MUL_EN replaces the iterative
// multiply with a single combinational multiplier; divides are unaffected.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic        iCLK,
    input  logic        iRSTn,
    muldiv_seq_if.slave bus
);
    localparam logic [4:0] OPMUL    = 5'd10;
    localparam logic [4:0] OPMULH   = 5'd11;
    localparam logic [4:0] OPMULHSU = 5'd12;
    localparam logic [4:0] OPMULHU  = 5'd13;
    localparam logic [4:0] OPDIV    = 5'd14;
    localparam logic [4:0] OPDIVU   = 5'd15;
    localparam logic [4:0] OPREM    = 5'd16;
    localparam logic [4:0] OPREMU   = 5'd17;

    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [4:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             neg_q, neg_d, ill_q, ill_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d, illegal_q, illegal_d, done_q, done_d;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix, out_val;

`ifdef MULDIV_FAST_MUL_EN
    logic                      fast_q, fast_d;
    logic signed [2*WIDTH-1:0] fast_a, fast_b, fast_p;
`endif

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

    function automatic logic is_mul(input logic [4:0] op);
        return op inside {OPMUL, OPMULH, OPMULHSU, OPMULHU};
    endfunction

    function automatic logic is_div(input logic [4:0] op);
        return op inside {OPDIV, OPDIVU, OPREM, OPREMU};
    endfunction

    // Datapath for one radix-2 step, the sign fix-up and the final result select
    always_comb begin
        mul_sum   = {1'b0, hi_q} + {1'b0, ({WIDTH{lo_q[0]}} & a_q)};
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, b_q};
        prod_fix  = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        q_fix     = neg_q ? -lo_q : lo_q;
        r_fix     = neg_q ? -hi_q : hi_q;
`ifdef MULDIV_FAST_MUL_EN
        // Sign-extended 33-bit operands; only the low 64 product bits are kept
        fast_a  = {{WIDTH{(op_q == OPMULH || op_q == OPMULHSU) & a_q[WIDTH-1]}}, a_q};
        fast_b  = {{WIDTH{(op_q == OPMULH) & b_q[WIDTH-1]}}, b_q};
        fast_p  = fast_a * fast_b;
        out_val = !fast_q ? res_q :
                  (op_q == OPMUL) ? fast_p[WIDTH-1:0] : fast_p[2*WIDTH-1:WIDTH];
`else
        out_val = res_q;
`endif
    end

    // Next-state logic, operand capture, iteration and result registration
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        res_d     = res_q;
        neg_d     = neg_q;
        ill_d     = ill_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        done_d    = 1'b0;
`ifdef MULDIV_FAST_MUL_EN
        fast_d    = fast_q;
`endif
        if (bus.iKill) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.iStart) begin
                        op_d    = bus.iControl;
                        cnt_d   = '0;
                        hi_d    = '0;
                        a_d     = bus.iA;
                        b_d     = bus.iB;
                        lo_d    = bus.iB;
                        res_d   = '0;
                        neg_d   = 1'b0;
                        ill_d   = 1'b0;
                        state_d = CALC;
                        case (bus.iControl)
                            OPMULH: begin
                                a_d   = abs_val(bus.iA);
                                lo_d  = abs_val(bus.iB);
                                neg_d = bus.iA[WIDTH-1] ^ bus.iB[WIDTH-1];
                            end
                            OPMULHSU: begin
                                a_d   = abs_val(bus.iA);
                                neg_d = bus.iA[WIDTH-1];
                            end
                            OPDIV, OPREM: begin
                                b_d   = abs_val(bus.iB);
                                lo_d  = abs_val(bus.iA);
                                neg_d = (bus.iControl == OPDIV) ?
                                        (bus.iA[WIDTH-1] ^ bus.iB[WIDTH-1]) : bus.iA[WIDTH-1];
                            end
                            OPDIVU, OPREMU: lo_d = bus.iA;
                            OPMUL, OPMULHU: lo_d = bus.iB;
                            default: begin
                                ill_d   = 1'b1;
                                state_d = DONE;
                            end
                        endcase
                        if (is_div(bus.iControl) && bus.iB == '0) begin
                            res_d   = (bus.iControl inside {OPDIV, OPDIVU}) ? ALL_ONES : bus.iA;
                            state_d = DONE;
                        end else if ((bus.iControl inside {OPDIV, OPREM}) &&
                                     bus.iA == MIN_NEG && bus.iB == ALL_ONES) begin
                            res_d   = (bus.iControl == OPDIV) ? MIN_NEG : '0;
                            state_d = DONE;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        fast_d = is_mul(bus.iControl);
                        if (is_mul(bus.iControl)) begin
                            a_d     = bus.iA;
                            b_d     = bus.iB;
                            state_d = DONE;
                        end
`endif
                    end
                end
                CALC: begin
                    if (is_mul(op_q)) begin
                        hi_d = mul_sum[WIDTH:1];
                        lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
                    end else begin
                        hi_d = div_ge ? WIDTH'(div_shift - {1'b0, b_q}) : div_shift[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], div_ge};
                    end
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = FIX;
                    end
                end
                FIX: begin
                    if (is_mul(op_q)) begin
                        res_d = (op_q == OPMUL) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
                    end else if (op_q inside {OPDIV, OPDIVU}) begin
                        res_d = q_fix;
                    end else begin
                        res_d = r_fix;
                    end
                    state_d = DONE;
                end
                DONE: begin
                    result_d  = out_val;
                    zero_d    = (out_val == '0);
                    illegal_d = ill_q;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers; reset discards any operation in flight
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            res_q     <= '0;
            neg_q     <= 1'b0;
            ill_q     <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef MULDIV_FAST_MUL_EN
            fast_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            res_q     <= res_d;
            neg_q     <= neg_d;
            ill_q     <= ill_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            done_q    <= done_d;
`ifdef MULDIV_FAST_MUL_EN
            fast_q    <= fast_d;
`endif
        end
    end

    assign bus.oReady   = (state_q == IDLE);
    assign bus.oDone    = done_q;
    assign bus.oResult  = result_q;
    assign bus.oZero    = zero_q;
    assign bus.oIllegal = illegal_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: requests push expected results (from an
// arithmetic reference model) into a queue; a monitor pops on every oDone.
module tb_muldiv_seq;
    localparam logic [4:0] OPADD    = 5'd2;
    localparam logic [4:0] OPMUL    = 5'd10;
    localparam logic [4:0] OPMULH   = 5'd11;
    localparam logic [4:0] OPMULHSU = 5'd12;
    localparam logic [4:0] OPMULHU  = 5'd13;
    localparam logic [4:0] OPDIV    = 5'd14;
    localparam logic [4:0] OPDIVU   = 5'd15;
    localparam logic [4:0] OPREM    = 5'd16;
    localparam logic [4:0] OPREMU   = 5'd17;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    muldiv_seq_if #(.WIDTH(32)) bus ();
    muldiv_seq #(.WIDTH(32)) dut (.iCLK(clk), .iRSTn(rstn), .bus(bus));

    typedef struct {
        logic [31:0] res;
        logic        ill;
        int          done_cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          cyc   = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] prev;
    logic [4:0]  ops[9];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: RV32M results from plain 64-bit arithmetic
    function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ub = longint'({32'd0, b});
        logic [63:0] p;
        logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        e.ill = 1'b0;
        e.done_cyc = 0;
        e.res = '0;
        case (op)
            OPMUL:    begin p = sa * sb; e.res = p[31:0];  end
            OPMULH:   begin p = sa * sb; e.res = p[63:32]; end
            OPMULHSU: begin p = sa * ub; e.res = p[63:32]; end
            OPMULHU:  begin p = {32'd0, a} * {32'd0, b}; e.res = p[63:32]; end
            OPDIV:    e.res = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            OPDIVU:   e.res = (b == 0) ? 32'hFFFF_FFFF : a / b;
            OPREM:    e.res = (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            OPREMU:   e.res = (b == 0) ? a : a % b;
            default:  e.ill = 1'b1;
        endcase
        return e;
    endfunction

    // Cycles from the acceptance edge to the edge that raises oDone
    function automatic int latency(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!(op inside {OPMUL, OPMULH, OPMULHSU, OPMULHU, OPDIV, OPDIVU, OPREM, OPREMU})) return 1;
        if (op inside {OPDIV, OPDIVU, OPREM, OPREMU} && b == 0) return 1;
        if (op inside {OPDIV, OPREM} && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (op inside {OPMUL, OPMULH, OPMULHSU, OPMULHU}) return 1;
`endif
        return 34;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(15));
            default: return $urandom;
        endcase
    endfunction

    // Wait for oReady (optionally hammering iStart with junk), then present one request
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit noise, input bit track);
        exp_t e;
        @(negedge clk);
        for (int k = 0; k < 100 && !bus.oReady; k++) begin
            bus.iStart = noise;
            if (noise) begin
                bus.iControl = 5'($urandom);
                bus.iA       = $urandom;
                bus.iB       = $urandom;
            end
            @(negedge clk);
        end
        if (!bus.oReady) begin
            n_cmp++;
            n_err++;
            $display("FAIL ready_timeout: oReady=%0b, expected 1 within 100 cycles", bus.oReady);
            bus.iStart = 1'b0;
            return;
        end
        bus.iStart   = 1'b1;
        bus.iControl = op;
        bus.iA       = a;
        bus.iB       = b;
        if (track) begin
            e = model(op, a, b);
            e.done_cyc = cyc + 1 + latency(op, a, b);
            sb_q.push_back(e);
        end
    endtask

    task automatic drain();
        @(negedge clk);
        bus.iStart = 1'b0;
        for (int k = 0; k < 200 && sb_q.size() != 0; k++) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ready"},   32'(bus.oReady),   32'd1);
        chk({tag, "_done"},    32'(bus.oDone),    32'd0);
        chk({tag, "_result"},  bus.oResult,       32'd0);
        chk({tag, "_zero"},    32'(bus.oZero),    32'd1);
        chk({tag, "_illegal"}, 32'(bus.oIllegal), 32'd0);
    endtask

    // Monitor: every oDone must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (rstn && bus.oDone) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: oDone=1 result=0x%08h, expected no completion", bus.oResult);
            end else begin
                e = sb_q.pop_front();
                chk("result",  bus.oResult,        e.res);
                chk("zero",    32'(bus.oZero),     32'(e.res == 0));
                chk("illegal", 32'(bus.oIllegal),  32'(e.ill));
                chk("latency", 32'(cyc),           32'(e.done_cyc));
                chk("ready_in_done", 32'(bus.oReady), 32'd1);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ops = '{OPMUL, OPMULH, OPMULHSU, OPMULHU, OPDIV, OPDIVU, OPREM, OPREMU, OPADD};
        bus.iStart = 1'b0;
        bus.iKill = 1'b0;
        bus.iControl = OPADD;
        bus.iA = '0;
        bus.iB = '0;
        repeat (2) @(negedge clk);
        chk_reset_values("reset");
        rstn = 1'b1;

        issue(OPDIV, 32'd8, 32'd3, 0, 1);
        issue(OPREM, 32'd8, 32'd3, 0, 1);
        issue(OPDIVU, 32'hFFFF_FFF0, 32'd4, 0, 1);
        issue(OPREMU, 32'hFFFF_FFF0, 32'd12, 0, 1);
        issue(OPDIV, 32'hFFFF_FFF8, 32'd2, 0, 1);
        issue(OPDIV, 32'd5, 32'd0, 0, 1);
        issue(OPREM, 32'd5, 32'd0, 0, 1);
        issue(OPDIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1);
        issue(OPREM, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1);
        issue(OPMULHU, 32'hFFFF_FFFF, 32'd3, 0, 1);
        issue(OPMULH, 32'hFFFF_FFFF, 32'd3, 0, 1);
        issue(OPMULHSU, 32'hFFFF_FFFF, 32'd3, 0, 1);
        issue(OPMUL, 32'hFFFF_FFFF, 32'd3, 0, 1);
        issue(OPADD, 32'd1, 32'd2, 0, 1);
        issue(OPDIVU, 32'd100, 32'd7, 0, 1);
        issue(OPMUL, 32'h1234_5678, 32'h9ABC_DEF0, 1, 1);
        issue(OPREM, 32'hFFFF_FF9C, 32'd7, 1, 1);
        drain();

        for (int i = 0; i < 60; i++) begin
            issue(ops[$urandom_range(8)], pick_operand(), pick_operand(), (i % 3) == 0, 1);
        end
        drain();

        // Kill during CALC: back to IDLE, no completion, result untouched
        prev = bus.oResult;
        issue(OPDIVU, 32'h1234_5678, 32'd9, 0, 0);
        @(negedge clk);
        bus.iStart = 1'b0;
        repeat (9) @(negedge clk);
        bus.iKill = 1'b1;
        @(negedge clk);
        bus.iKill = 1'b0;
        chk("kill_ready",  32'(bus.oReady), 32'd1);
        chk("kill_result", bus.oResult,     prev);
        repeat (45) @(negedge clk);

        // Kill and start together in IDLE: request dropped
        bus.iStart = 1'b1;
        bus.iKill = 1'b1;
        bus.iControl = OPDIV;
        bus.iA = 32'd8;
        bus.iB = 32'd3;
        @(negedge clk);
        bus.iStart = 1'b0;
        bus.iKill = 1'b0;
        chk("killstart_ready",  32'(bus.oReady), 32'd1);
        chk("killstart_result", bus.oResult,     prev);
        repeat (40) @(negedge clk);

        // Asynchronous reset mid-operation
        issue(OPDIV, 32'd1000, 32'd7, 0, 0);
        @(negedge clk);
        bus.iStart = 1'b0;
        repeat (9) @(negedge clk);
        #2 rstn = 1'b0;
        #1 chk_reset_values("midreset");
        @(negedge clk);
        rstn = 1'b1;
        repeat (40) @(negedge clk);

        issue(OPREM, 32'd8, 32'd3, 0, 1);
        issue(OPMULH, 32'h8000_0000, 32'h8000_0000, 0, 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
